// File: rtl/keypad_scan.sv
`timescale 1ns / 1ps
// keypad_scan
// Scans a 4x4 matrix keypad one column at a time, debounces presses and
// releases, and reports accepted keys as hex codes.
//
// Ports
//   clk_i        : single clock, all logic on the rising edge
//   rst_i        : synchronous active-high reset
//   row_i[3:0]   : keypad rows, asynchronous, active-low (pulled up)
//   col_o[3:0]   : column drive, active-low one-hot
//   key_o[3:0]   : hex code of the last accepted key
//   key_valid_o  : one-cycle pulse when a key is accepted
//   key_held_o   : high while an accepted key remains pressed
//   hex_o[15:0]  : last four accepted codes, newest in [3:0]
//
// FSM state is held in r_state (type state_t) for checkers to bind to.
module keypad_scan #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  output logic [3:0]  key_o,
  output logic        key_valid_o,
  output logic        key_held_o,
  output logic [15:0] hex_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HOLD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t           r_state, w_state;
  logic [3:0]       r_sync1, r_sync2;
  logic [1:0]       r_col, w_col;
  logic [1:0]       r_row, w_row;
  logic [DIV_W-1:0] r_dwell, w_dwell;
  logic [DB_W-1:0]  r_db, w_db;
  logic [3:0]       r_key, w_key;
  logic [15:0]      r_hex, w_hex;
  logic             r_valid, w_valid;

  logic             w_all_high;
  logic             w_row_low;
  logic [1:0]       w_first_low;
  logic [3:0]       w_code;

  // Row r, column c -> hex code printed on the key.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign w_all_high = &r_sync2;
  assign w_row_low  = ~r_sync2[r_row];
  assign w_code     = map_key(r_row, r_col);

  // Lowest-numbered low row wins when several rows are low at once.
  always_comb begin
    w_first_low = 2'd3;
    if (!r_sync2[0])      w_first_low = 2'd0;
    else if (!r_sync2[1]) w_first_low = 2'd1;
    else if (!r_sync2[2]) w_first_low = 2'd2;
  end

  // State register plus datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_SCAN;
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_col   <= 2'd0;
      r_row   <= 2'd0;
      r_dwell <= '0;
      r_db    <= '0;
      r_key   <= 4'h0;
      r_hex   <= 16'h0000;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sync1 <= row_i;
      r_sync2 <= r_sync1;
      r_col   <= w_col;
      r_row   <= w_row;
      r_dwell <= w_dwell;
      r_db    <= w_db;
      r_key   <= w_key;
      r_hex   <= w_hex;
      r_valid <= w_valid;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_row   = r_row;
    w_dwell = r_dwell;
    w_db    = r_db;
    w_key   = r_key;
    w_hex   = r_hex;
    w_valid = 1'b0;
    case (r_state)
      S_SCAN: begin
        if (r_dwell == DIV_LAST) begin
          w_dwell = '0;
          if (w_all_high) begin
            w_col = r_col + 2'd1;
          end else begin
            w_row   = w_first_low;
            w_db    = '0;
            w_state = S_DEBOUNCE;
          end
        end else begin
          w_dwell = r_dwell + DIV_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (!w_row_low) begin
          // Bounce: give up on this column and keep scanning.
          w_state = S_SCAN;
          w_col   = r_col + 2'd1;
          w_dwell = '0;
        end else if (r_db == DB_LAST) begin
          w_key   = w_code;
          w_hex   = {r_hex[11:0], w_code};
          w_valid = 1'b1;
          w_state = S_HOLD;
        end else begin
          w_db = r_db + DB_W'(1);
        end
      end
      S_HOLD: begin
        // Only all-rows-high leaves HOLD, so extra keys are ignored.
        if (w_all_high) begin
          w_state = S_RELEASE;
          w_db    = '0;
        end
      end
      S_RELEASE: begin
        if (!w_all_high) begin
          w_state = S_HOLD;
        end else if (r_db == DB_LAST) begin
          w_state = S_SCAN;
          w_col   = r_col + 2'd1;
          w_dwell = '0;
          w_db    = '0;
        end else begin
          w_db = r_db + DB_W'(1);
        end
      end
      default: w_state = S_SCAN;
    endcase
  end

  assign col_o       = ~(4'b0001 << r_col);
  assign key_o       = r_key;
  assign key_valid_o = r_valid;
  assign key_held_o  = (r_state == S_HOLD) || (r_state == S_RELEASE);
  assign hex_o       = r_hex;

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven before rows are sampled (minimum 4).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 100000: consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port row_i, input, 4 bits: keypad rows, asynchronous, active-low (pulled up), bit r = row r.
REQ-006 The block SHALL have port col_o, output, 4 bits: column drive, active-low one-hot, bit c = column c.
REQ-007 The block SHALL have port key_o, output, 4 bits: hex code of the last accepted key.
REQ-008 The block SHALL have port key_valid_o, output, 1 bit: one-cycle pulse when a key is accepted.
REQ-009 The block SHALL have port key_held_o, output, 1 bit: high while an accepted key remains pressed.
REQ-010 The block SHALL have port hex_o, output, 16 bits: the last four accepted codes, newest in [3:0], directly drivable into the 4-digit display driver.

Function
REQ-011 row_i SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rows_s), adding 2 cycles of input latency.
REQ-012 Key map (row r, column c) SHALL be: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D, for c = 0..3.
REQ-013 The FSM SHALL have states SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-014 SCAN: a dwell counter SHALL count 0..SCAN_DIV-1 with the current column driven; at count SCAN_DIV-1, if rows_s = 4'b1111, the column index SHALL advance (3 wraps to 0) and the counter SHALL clear.
REQ-015 SCAN: at count SCAN_DIV-1, if any rows_s bit is 0, the block SHALL latch the column index and the lowest-numbered low row, then enter DEBOUNCE with the debounce counter cleared.
REQ-016 DEBOUNCE: the column SHALL stay driven; each cycle the latched row is low, the counter SHALL increment; if the latched row reads high, the block SHALL return to SCAN with the column advanced and no output change.
REQ-017 DEBOUNCE: when the counter reaches DEBOUNCE_CYCLES-1 with the row still low, on the next edge key_o SHALL take the mapped code, hex_o SHALL become {hex_o[11:0], code}, key_valid_o SHALL be 1 for exactly that cycle, and the state SHALL become HOLD.
REQ-018 HOLD: key_held_o SHALL be 1 and the column SHALL stay driven; when rows_s = 4'b1111 the block SHALL enter RELEASE with the counter cleared; other rows going low SHALL be ignored (no rollover).
REQ-019 RELEASE: key_held_o SHALL remain 1; any low row SHALL return the block to HOLD; DEBOUNCE_CYCLES consecutive all-high cycles SHALL return it to SCAN with the column advanced and key_held_o cleared.
REQ-020 key_valid_o SHALL never be high for two consecutive cycles, and SHALL pulse at most once per press.
REQ-021 key_o and hex_o SHALL change only on a key_valid_o cycle.
REQ-022 col_o SHALL always be exactly one-hot active-low; no column change SHALL occur outside SCAN or the exits of DEBOUNCE and RELEASE.
REQ-023 Counters SHALL be sized by $clog2 of their parameter and SHALL not wrap during normal operation.

Reset
REQ-024 While rst_i = 1 at a clock edge: state = SCAN, column index = 0, col_o = 4'b1110, all counters = 0, key_o = 4'h0, key_valid_o = 0, key_held_o = 0, hex_o = 16'h0000, synchronizer flops = 4'b1111.
REQ-025 Reset asserted mid-DEBOUNCE, HOLD or RELEASE SHALL abort the operation with no key_valid_o pulse; after release from reset, scanning SHALL restart at column 0.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset then idle rows 4'b1111 -> col_o cycles 1110, 1101, 1011, 0111, 1110 with 4 cycles per column; key_valid_o stays 0.
REQ-027 Hold row 1 low only while column 2 is driven, for 30 cycles -> single key_valid_o pulse, key_o = 4'h6, hex_o = 16'h0006, key_held_o = 1 until release debounce completes.
REQ-028 Press 1, 2, 3, A, 5 in sequence with full releases -> hex_o = 16'h23A5 and exactly five key_valid_o pulses.
REQ-029 Row 0 glitches low for 3 cycles on column 0 -> no key_valid_o; scanning resumes at column 1.
REQ-030 Row 3 column 3 held; bounce high for 2 cycles during RELEASE, then stays high -> exactly one key_valid_o (key_o = 4'hD); key_held_o drops only after 8 clean high cycles.
REQ-031 rst_i asserted at DEBOUNCE count 5 -> no pulse, all outputs equal reset values on the next cycle, col_o = 4'b1110.
